ppu_vram_bus_sequencer: RTL and testbench
=========================================

Name: ppu_vram_bus_sequencer

Overview:
- Sequences the PPU external VRAM bus: ALE address phase, then RD or WR strobe phase.
- Drives the pad block's n_ALE_topad, RD_topad, WR_topad and n_PA[13:0] inputs, and captures read data from PD_out.
- Arbitrates the bus between the render fetch pipeline (default priority) and the CPU data port ($2007). A starvation limit guarantees the CPU a slot.

Parameters:
- ADDR_W, 14, VRAM address width.
- DATA_W, 8, data width.
- STARVE_MAX, 4, max consecutive render grants while a CPU request waits; range 1..15.

Ports:
- PCLK  in  1  PPU clock; all state updates on rising edge.
- RES  in  1  reset, synchronous, active-high.
- render_en  in  1  rendering enabled; when 0, render requests are ignored.
- rend_req  in  1  render fetch request; level, held until rend_ack.
- rend_addr  in  ADDR_W  render fetch address.
- rend_ack  out  1  one-cycle pulse in the ALE cycle of a granted render access.
- rend_rvalid  out  1  one-cycle pulse; rdata holds render read data.
- cpu_rd_req  in  1  CPU read request; level, held until cpu_ack.
- cpu_wr_req  in  1  CPU write request; level, held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle pulse in the ALE cycle of a granted CPU access.
- cpu_rvalid  out  1  one-cycle pulse; rdata holds CPU read data.
- rdata  out  DATA_W  captured read data; holds its value until the next capture.
- PD_in  in  DATA_W  read data from the pad block (PD_out).
- n_ALE_topad  out  1  active-low ALE to pads.
- RD_topad  out  1  read strobe to pads; when 1 the AD output drivers are off.
- WR_topad  out  1  write strobe to pads.
- n_PA  out  ADDR_W  inverted address; during a write strobe, bits [7:0] carry ~wdata.

Behaviour:
- Reset (RES=1 at an edge):
  - state=IDLE, n_ALE_topad=1, RD_topad=0, WR_topad=0, n_PA=all ones.
  - All ack/rvalid outputs 0, rdata=0, starve counter=0.
  - Reset mid-access aborts it: no rvalid, strobes drop the next cycle.
- All pad-facing outputs are registered.
- States: IDLE, ALE, STROBE.
  - Arbitration happens at any edge where the next state would be IDLE or ALE, i.e. from IDLE or from STROBE.
  - Granted: next state=ALE; otherwise IDLE.
  - ALE always goes to STROBE.
- ALE cycle:
  - n_ALE_topad=0, n_PA=~addr, RD=WR=0.
  - Matching ack=1 for this cycle only.
- STROBE cycle, read: RD_topad=1, n_PA[13:8]=~addr[13:8], n_PA[7:0]=all ones.
- STROBE cycle, write: WR_topad=1, n_PA[13:8]=~addr[13:8], n_PA[7:0]=~wdata.
- Read data capture:
  - At the edge ending a read STROBE, rdata<=PD_in.
  - The matching rvalid=1 in the following cycle.
  - Read latency: ack cycle + 2 cycles to rvalid.
- Throughput: back-to-back accesses every 2 cycles (STROBE -> ALE with no IDLE gap).
- Arbitration:
  - Render is eligible when rend_req && render_en.
  - CPU wins if it is the only eligible requester, or if the starve counter == STARVE_MAX.
  - Otherwise render wins.
- Starve counter:
  - Increments on each render grant while a CPU request is pending, saturating at STARVE_MAX.
  - Clears on a CPU grant, and whenever no CPU request is pending.
- Address and data are latched at grant; requester inputs may change after ack.
- cpu_rd_req and cpu_wr_req both high: the write is performed, the read is ignored, and a single cpu_ack is issued.
- A requester that deasserts its request before ack is simply not granted.
- render_en falling mid-access: the in-flight access completes normally.

Decomposition:
- Package ppu_vram_pkg holds:
  - the state encoding (IDLE/ALE/STROBE);
  - the owner encoding (OWN_REND, OWN_CPU);
  - the ADDR_W and DATA_W defaults.
- One sub-module, ppu_vram_arb: the combinational priority decision plus the starve counter register. Inputs: eligibility and grant-accept; outputs: the winner.
- The sequencing FSM and output registers stay in the top block.

Test Plan:
- Reset check: assert RES for 2 cycles with both requests high -> n_ALE_topad=1, RD=WR=0, n_PA=14'h3FFF, no acks, rdata=0.
- CPU read, addr=14'h2345, PD_in=8'hA5 during STROBE:
  - cycle0: cpu_ack, n_ALE_topad=0, n_PA=~14'h2345.
  - cycle1: RD_topad=1, n_PA[7:0]=8'hFF, n_PA[13:8]=~6'h23.
  - cycle2: cpu_rvalid=1, rdata=8'hA5.
- CPU write, addr=14'h3F00, wdata=8'h3C -> ALE cycle n_PA=~14'h3F00; STROBE WR_topad=1, n_PA[7:0]=8'hC3; no rvalid.
- Contention, rend_req and cpu_rd_req held continuously, render_en=1, STARVE_MAX=4 -> grant sequence R,R,R,R,C,R,R,R,R,C; accesses every 2 cycles with no IDLE gap.
- render_en=0 with rend_req=1 -> bus stays IDLE, no rend_ack; then raise cpu_wr_req -> CPU granted on the next edge.
- RES asserted during a read STROBE -> next cycle RD_topad=0, no cpu_rvalid; re-request succeeds normally after RES drops.

Source files
------------

// File: rtl/ppu_vram_pkg.sv
// Shared types for the PPU VRAM bus sequencer.
// State and owner encodings plus default bus widths.
package ppu_vram_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALE    = 2'd1,
        ST_STROBE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_REND = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

endpackage

// File: rtl/ppu_vram_bus_sequencer_arb.sv
// Render/CPU bus arbiter with a starvation counter
// that forces a CPU slot after STARVE_MAX render wins.
module ppu_vram_arb
    import ppu_vram_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rend_elig,
    input  logic   cpu_elig,
    input  logic   accept,
    output logic   grant_valid,
    output owner_e grant_owner
);

    localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       cpu_win;
    logic       rend_win;

    // Priority decision and next starve count
    always_comb begin
        cpu_win     = cpu_elig && (!rend_elig || starve_q == MAX_CNT);
        rend_win    = rend_elig && !cpu_win;
        grant_valid = accept && (cpu_win || rend_win);
        grant_owner = cpu_win ? OWN_CPU : OWN_REND;
        starve_d    = starve_q;
        if (!cpu_elig || (accept && cpu_win)) begin
            starve_d = 4'd0;
        end else if (accept && rend_win && starve_q != MAX_CNT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starve counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ppu_vram_bus_sequencer.sv
// PPU external VRAM bus sequencer: ALE phase then RD/WR
// strobe, shared between render fetches and CPU $2007.
module ppu_vram_bus_sequencer
    import ppu_vram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              PCLK,
    input  logic              RES,
    input  logic              render_en,
    input  logic              rend_req,
    input  logic [ADDR_W-1:0] rend_addr,
    output logic              rend_ack,
    output logic              rend_rvalid,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] PD_in,
    output logic              n_ALE_topad,
    output logic              RD_topad,
    output logic              WR_topad,
    output logic [ADDR_W-1:0] n_PA
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              n_ale_q, n_ale_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] n_pa_q, n_pa_d;
    logic              rend_ack_q, rend_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              rend_rv_q, rend_rv_d;
    logic              cpu_rv_q, cpu_rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic   grant_valid;
    owner_e grant_owner;
    logic   accept;

    assign accept = (state_q != ST_ALE);

    ppu_vram_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (PCLK),
        .rst         (RES),
        .rend_elig   (rend_req && render_en),
        .cpu_elig    (cpu_rd_req || cpu_wr_req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Sequencing FSM, access latch and pad output next-values
    always_comb begin
        state_d    = ST_IDLE;
        owner_d    = owner_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        n_ale_d    = 1'b1;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        n_pa_d     = '1;
        rend_ack_d = 1'b0;
        cpu_ack_d  = 1'b0;
        rend_rv_d  = 1'b0;
        cpu_rv_d   = 1'b0;
        rdata_d    = rdata_q;

        if (state_q == ST_STROBE && !is_wr_q) begin
            rdata_d   = PD_in;
            rend_rv_d = (owner_q == OWN_REND);
            cpu_rv_d  = (owner_q == OWN_CPU);
        end

        unique case (state_q)
            ST_ALE: begin
                state_d = ST_STROBE;
                rd_d    = !is_wr_q;
                wr_d    = is_wr_q;
                if (is_wr_q) begin
                    n_pa_d = ~{addr_q[ADDR_W-1:DATA_W], wdata_q};
                end else begin
                    n_pa_d = ~{addr_q[ADDR_W-1:DATA_W], {DATA_W{1'b0}}};
                end
            end
            default: begin
                if (grant_valid) begin
                    state_d = ST_ALE;
                    owner_d = grant_owner;
                    if (grant_owner == OWN_CPU) begin
                        addr_d    = cpu_addr;
                        wdata_d   = cpu_wdata;
                        is_wr_d   = cpu_wr_req;
                        cpu_ack_d = 1'b1;
                    end else begin
                        addr_d     = rend_addr;
                        is_wr_d    = 1'b0;
                        rend_ack_d = 1'b1;
                    end
                    n_ale_d = 1'b0;
                    n_pa_d  = ~addr_d;
                end
            end
        endcase
    end

    // State and registered pad/handshake outputs
    always_ff @(posedge PCLK) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_REND;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_ale_q    <= 1'b1;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            n_pa_q     <= '1;
            rend_ack_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            rend_rv_q  <= 1'b0;
            cpu_rv_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_ale_q    <= n_ale_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            n_pa_q     <= n_pa_d;
            rend_ack_q <= rend_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            rend_rv_q  <= rend_rv_d;
            cpu_rv_q   <= cpu_rv_d;
            rdata_q    <= rdata_d;
        end
    end

    assign n_ALE_topad = n_ale_q;
    assign RD_topad    = rd_q;
    assign WR_topad    = wr_q;
    assign n_PA        = n_pa_q;
    assign rend_ack    = rend_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign rend_rvalid = rend_rv_q;
    assign cpu_rvalid  = cpu_rv_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_ppu_vram_bus_sequencer.sv
// Bench for the VRAM bus sequencer: a cycle-timeline
// model plus directed literal checks and random traffic.
module tb_ppu_vram_bus_sequencer;

    localparam int SMAX = 4;

    logic        PCLK = 1'b0;
    logic        RES = 1'b1;
    logic        render_en = 1'b0;
    logic        rend_req = 1'b0;
    logic [13:0] rend_addr = '0;
    logic        rend_ack;
    logic        rend_rvalid;
    logic        cpu_rd_req = 1'b0;
    logic        cpu_wr_req = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  rdata;
    logic [7:0]  PD_in = '0;
    logic        n_ALE_topad;
    logic        RD_topad;
    logic        WR_topad;
    logic [13:0] n_PA;

    ppu_vram_bus_sequencer #(
        .ADDR_W     (14),
        .DATA_W     (8),
        .STARVE_MAX (SMAX)
    ) dut (
        .PCLK        (PCLK),
        .RES         (RES),
        .render_en   (render_en),
        .rend_req    (rend_req),
        .rend_addr   (rend_addr),
        .rend_ack    (rend_ack),
        .rend_rvalid (rend_rvalid),
        .cpu_rd_req  (cpu_rd_req),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rvalid  (cpu_rvalid),
        .rdata       (rdata),
        .PD_in       (PD_in),
        .n_ALE_topad (n_ALE_topad),
        .RD_topad    (RD_topad),
        .WR_topad    (WR_topad),
        .n_PA        (n_PA)
    );

    always #5 PCLK = ~PCLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act,
                           input string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    // Expected outputs of one cycle
    typedef struct packed {
        logic        ale;
        logic        rd;
        logic        wr;
        logic [13:0] npa;
        logic        npa_chk;
        logic        rack;
        logic        cack;
        logic        rrv;
        logic        crv;
    } exp_t;

    // Timeline model: plan[k] holds outputs reserved for cycle k,
    // cap[k] marks a read capture at edge k (value 1 = CPU owner).
    exp_t  plan [int];
    bit    cap [int];
    int    k = 0;
    int    starve = 0;
    logic [7:0] m_rdata = '0;
    exp_t  exp_now = '0;
    logic [7:0] exp_rdata = '0;
    bit    m_valid = 1'b0;
    string glog = "";

    always @(posedge PCLK) begin
        exp_t e;
        exp_t s;
        bit free;
        bit gc;
        bit gr;
        bit cpu_p;
        bit rend_e;
        bit w;
        logic [13:0] a;
        logic [7:0] d;
        e = '0;
        if (RES) begin
            plan.delete();
            cap.delete();
            m_rdata = '0;
            starve = 0;
            e.npa = '1;
            e.npa_chk = 1'b1;
        end else begin
            free = !plan.exists(k);
            if (!free) e = plan[k];
            if (cap.exists(k)) begin
                m_rdata = PD_in;
                if (cap[k]) e.crv = 1'b1;
                else e.rrv = 1'b1;
            end
            cpu_p = cpu_rd_req || cpu_wr_req;
            rend_e = rend_req && render_en;
            gc = 1'b0;
            gr = 1'b0;
            if (free) begin
                gc = cpu_p && (!rend_e || starve == SMAX);
                gr = rend_e && !gc;
            end
            if (gc || gr) begin
                w = gc && cpu_wr_req;
                a = gc ? cpu_addr : rend_addr;
                d = cpu_wdata;
                e.ale = 1'b1;
                e.npa = ~a;
                e.npa_chk = 1'b1;
                e.cack = gc;
                e.rack = gr;
                s = '0;
                s.rd = !w;
                s.wr = w;
                s.npa = w ? ~{a[13:8], d} : {~a[13:8], 8'hFF};
                s.npa_chk = 1'b1;
                plan[k+1] = s;
                if (!w) cap[k+2] = gc;
                if (gc) glog = {glog, "C"};
                else glog = {glog, "R"};
            end
            if (gc || !cpu_p) starve = 0;
            else if (gr && starve < SMAX) starve++;
            plan.delete(k);
            cap.delete(k);
        end
        exp_now = e;
        exp_rdata = m_rdata;
        m_valid = 1'b1;
        k++;
    end

    // Compare every cycle against the model
    always @(posedge PCLK) begin
        #1;
        if (m_valid) begin
            chk("n_ALE", 32'(n_ALE_topad), 32'(!exp_now.ale));
            chk("RD", 32'(RD_topad), 32'(exp_now.rd));
            chk("WR", 32'(WR_topad), 32'(exp_now.wr));
            chk("rend_ack", 32'(rend_ack), 32'(exp_now.rack));
            chk("cpu_ack", 32'(cpu_ack), 32'(exp_now.cack));
            chk("rend_rvalid", 32'(rend_rvalid), 32'(exp_now.rrv));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_now.crv));
            chk("rdata", 32'(rdata), 32'(exp_rdata));
            if (exp_now.npa_chk) chk("n_PA", 32'(n_PA), 32'(exp_now.npa));
        end
    end

    task automatic wait_ack(input bit cpu, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge PCLK);
            #1;
            if (cpu ? cpu_ack : rend_ack) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: no ack within 8 cycles", name);
        end
    endtask

    initial begin
        string dlog;
        int ales;

        // Reset with both requesters active
        RES = 1'b1;
        render_en = 1'b1;
        rend_req = 1'b1;
        cpu_rd_req = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_nale", 32'(n_ALE_topad), 32'd1);
        chk("rst_rd", 32'(RD_topad), 32'd0);
        chk("rst_wr", 32'(WR_topad), 32'd0);
        chk("rst_npa", 32'(n_PA), 32'h3FFF);
        chk("rst_acks", 32'({rend_ack, cpu_ack}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge PCLK);
        RES = 1'b0;
        rend_req = 1'b0;
        cpu_rd_req = 1'b0;
        @(negedge PCLK);

        // CPU read
        cpu_addr = 14'h2345;
        cpu_rd_req = 1'b1;
        PD_in = 8'hA5;
        wait_ack(1'b1, "rd_ack");
        chk("rd_ale_nale", 32'(n_ALE_topad), 32'd0);
        chk("rd_ale_npa", 32'(n_PA), 32'h1CBA);
        @(negedge PCLK);
        cpu_rd_req = 1'b0;
        @(posedge PCLK);
        #1;
        chk("rd_stb_rd", 32'(RD_topad), 32'd1);
        chk("rd_stb_npa", 32'(n_PA), 32'h1CFF);
        @(posedge PCLK);
        #1;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", 32'(rdata), 32'hA5);

        // CPU write
        @(negedge PCLK);
        cpu_addr = 14'h3F00;
        cpu_wdata = 8'h3C;
        cpu_wr_req = 1'b1;
        wait_ack(1'b1, "wr_ack");
        chk("wr_ale_npa", 32'(n_PA), 32'h00FF);
        @(negedge PCLK);
        cpu_wr_req = 1'b0;
        @(posedge PCLK);
        #1;
        chk("wr_stb_wr", 32'(WR_topad), 32'd1);
        chk("wr_stb_npa", 32'(n_PA), 32'h00C3);
        @(posedge PCLK);
        #1;
        chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);

        // Render disabled: requests ignored, CPU then wins
        @(negedge PCLK);
        render_en = 1'b0;
        rend_req = 1'b1;
        rend_addr = 14'h0ABC;
        repeat (5) begin
            @(posedge PCLK);
            #1;
            chk("dis_rend_ack", 32'(rend_ack), 32'd0);
            chk("dis_idle", 32'(n_ALE_topad), 32'd1);
        end
        @(negedge PCLK);
        cpu_addr = 14'h0123;
        cpu_wdata = 8'h55;
        cpu_wr_req = 1'b1;
        @(posedge PCLK);
        #1;
        chk("dis_cpu_ack", 32'(cpu_ack), 32'd1);
        @(negedge PCLK);
        cpu_wr_req = 1'b0;
        rend_req = 1'b0;
        render_en = 1'b1;
        repeat (2) @(negedge PCLK);

        // Contention with both requests held
        glog = "";
        dlog = "";
        ales = 0;
        rend_req = 1'b1;
        cpu_rd_req = 1'b1;
        cpu_addr = 14'h2000;
        rend_addr = 14'h0010;
        repeat (20) begin
            @(posedge PCLK);
            #1;
            if (rend_ack) dlog = {dlog, "R"};
            if (cpu_ack) dlog = {dlog, "C"};
            if (!n_ALE_topad) ales++;
        end
        chk_str("cont_dut_seq", dlog, "RRRRCRRRRC");
        chk_str("cont_model_seq", glog, "RRRRCRRRRC");
        chk("cont_ale_count", 32'(ales), 32'd10);
        @(negedge PCLK);
        rend_req = 1'b0;
        cpu_rd_req = 1'b0;
        repeat (3) @(negedge PCLK);

        // Reset during a read strobe
        cpu_addr = 14'h0777;
        cpu_rd_req = 1'b1;
        PD_in = 8'h99;
        wait_ack(1'b1, "rst_rd_ack");
        @(negedge PCLK);
        cpu_rd_req = 1'b0;
        @(posedge PCLK);
        #1;
        chk("rst_stb_rd", 32'(RD_topad), 32'd1);
        @(negedge PCLK);
        RES = 1'b1;
        @(posedge PCLK);
        #1;
        chk("abort_rd", 32'(RD_topad), 32'd0);
        chk("abort_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge PCLK);
        RES = 1'b0;
        @(posedge PCLK);
        #1;
        chk("abort_rvalid2", 32'(cpu_rvalid), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        @(negedge PCLK);
        cpu_addr = 14'h1111;
        cpu_rd_req = 1'b1;
        PD_in = 8'h5A;
        wait_ack(1'b1, "rereq_ack");
        @(negedge PCLK);
        cpu_rd_req = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rereq_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rereq_rdata", 32'(rdata), 32'h5A);

        // Random traffic against the model
        repeat (3000) begin
            @(negedge PCLK);
            if (cpu_ack) begin
                cpu_rd_req = 1'b0;
                cpu_wr_req = 1'b0;
            end
            if (rend_ack) rend_req = 1'b0;
            if ($urandom_range(0, 40) == 0) begin
                cpu_rd_req = 1'b0;
                cpu_wr_req = 1'b0;
            end
            if (!cpu_rd_req && !cpu_wr_req &&
                $urandom_range(0, 3) == 0) begin
                cpu_rd_req = 1'($urandom);
                cpu_wr_req = 1'($urandom);
                if (!cpu_wr_req) cpu_rd_req = 1'b1;
                cpu_addr = 14'($urandom);
                cpu_wdata = 8'($urandom);
            end
            if (!rend_req && $urandom_range(0, 1) == 1) begin
                rend_req = 1'b1;
                rend_addr = 14'($urandom);
            end
            if ($urandom_range(0, 15) == 0) render_en = ~render_en;
            RES = ($urandom_range(0, 99) == 0);
            PD_in = 8'($urandom);
        end
        @(negedge PCLK);
        RES = 1'b0;
        rend_req = 1'b0;
        cpu_rd_req = 1'b0;
        cpu_wr_req = 1'b0;
        repeat (4) @(negedge PCLK);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
